point_subtraction: RTL and testbench

POINT_SUBTRACTION -- requirements
Module: point_subtraction

---
 rtl/point_subtraction.sv | 192 +++++++++++++++++++
 tb/tb_point_subtraction.sv | 114 +++++++++++
 2 files changed

// File: rtl/point_subtraction.sv
// point_subtraction: affine R = P - Q over GF(p); POINT_SUBTRACTION_DOUBLE_EN compiles in the doubling case
module point_subtraction #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         busy,
  output logic         result,
  output logic         infinity
);
  localparam int CW = $clog2(2*n+1);
  localparam logic [CW-1:0] MUL_LAST = CW'(n-1);
  localparam logic [CW-1:0] INV_LAST = CW'(2*n);
  typedef enum logic [3:0] {IDLE, NEG, CHECK, NUM, INV, SLOPE, X3, Y3, DONE} state_t;
  typedef struct packed {
    logic [n-1:0]  p, a, x1, y1, x2, y2;
    logic [n-1:0]  num, u, v, ia, ib;
    logic [n-1:0]  ma, mb, acc;
    logic [n-1:0]  rx, ry, x3, y3;
    logic [CW-1:0] cnt;
    logic          busy, result, inf, inf_pend, dbl;
  } dp_t;
  state_t state_q, state_d;
  dp_t dp_q, dp_d;
  logic [n-1:0] acc_dbl, acc_nx, rx_new;
  logic mul_last;
  function automatic logic [n-1:0] add_mod(input logic [n-1:0] x, input logic [n-1:0] y, input logic [n-1:0] m);
    logic [n:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, m}) ? s[n-1:0] - m : s[n-1:0];
  endfunction
  function automatic logic [n-1:0] sub_mod(input logic [n-1:0] x, input logic [n-1:0] y, input logic [n-1:0] m);
    return (x >= y) ? x - y : x - y + m;
  endfunction
  function automatic logic [n-1:0] half_mod(input logic [n-1:0] x, input logic [n-1:0] m);
    logic [n:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, m} : {(n+1){1'b0}});
    return t[n:1];
  endfunction
  assign acc_dbl  = add_mod(dp_q.acc, dp_q.acc, dp_q.p);
  assign acc_nx   = dp_q.mb[n-1] ? add_mod(acc_dbl, dp_q.ma, dp_q.p) : acc_dbl;
  assign mul_last = dp_q.cnt == MUL_LAST;
  assign rx_new   = sub_mod(sub_mod(acc_nx, dp_q.x1, dp_q.p), dp_q.x2, dp_q.p);
`ifdef POINT_SUBTRACTION_DOUBLE_EN
  logic [n-1:0] tri_sq_a;
  assign tri_sq_a = add_mod(add_mod(add_mod(acc_nx, acc_nx, dp_q.p), acc_nx, dp_q.p), dp_q.a, dp_q.p);
`else
  logic unused_dp;
  assign unused_dp = ^{dp_q.a, dp_q.dbl};
`endif
  always_comb begin
    state_d = state_q;
    dp_d = dp_q;
    if (state_q inside {NUM, SLOPE, X3, Y3}) begin
      dp_d.acc = acc_nx;
      dp_d.mb  = dp_q.mb << 1;
      dp_d.cnt = dp_q.cnt + CW'(1);
    end
    case (state_q)
      IDLE: if (start) begin
        dp_d.p = p;
        dp_d.a = a;
        dp_d.x1 = x1;
        dp_d.y1 = y1;
        dp_d.x2 = x2;
        dp_d.y2 = y2;
        dp_d.busy = 1'b1;
        dp_d.result = 1'b0;
        dp_d.inf = 1'b0;
        dp_d.inf_pend = 1'b0;
        state_d = NEG;
      end
      NEG: begin
        dp_d.y2 = (dp_q.y2 == '0) ? '0 : dp_q.p - dp_q.y2;
        state_d = CHECK;
      end
      CHECK: begin
        dp_d.v = dp_q.p;
        dp_d.ia = n'(1);
        dp_d.ib = '0;
        dp_d.cnt = '0;
        dp_d.acc = '0;
        dp_d.num = sub_mod(dp_q.y1, dp_q.y2, dp_q.p);
        dp_d.u = sub_mod(dp_q.x1, dp_q.x2, dp_q.p);
        dp_d.dbl = 1'b0;
        state_d = NUM;
        if (dp_q.x1 == dp_q.x2) begin
`ifdef POINT_SUBTRACTION_DOUBLE_EN
          if (dp_q.y1 == dp_q.y2 && dp_q.y1 != '0) begin
            dp_d.dbl = 1'b1;
            dp_d.u = add_mod(dp_q.y1, dp_q.y1, dp_q.p);
            dp_d.ma = dp_q.x1;
            dp_d.mb = dp_q.x1;
          end else begin
            dp_d.inf_pend = 1'b1;
            state_d = DONE;
          end
`else
          dp_d.inf_pend = 1'b1;
          state_d = DONE;
`endif
        end
      end
      NUM: begin
`ifdef POINT_SUBTRACTION_DOUBLE_EN
        if (!dp_q.dbl || mul_last) begin
          dp_d.cnt = '0;
          state_d = INV;
        end
        if (dp_q.dbl && mul_last) dp_d.num = tri_sq_a;
`else
        dp_d.cnt = '0;
        state_d = INV;
`endif
      end
      INV: begin
        if (dp_q.u == n'(1) || dp_q.v == n'(1) || dp_q.cnt == INV_LAST) begin
          dp_d.ma = (dp_q.u == n'(1)) ? dp_q.ia : dp_q.ib;
          dp_d.mb = dp_q.num;
          dp_d.acc = '0;
          dp_d.cnt = '0;
          state_d = SLOPE;
        end else begin
          dp_d.cnt = dp_q.cnt + CW'(1);
          if (!dp_q.u[0]) begin
            dp_d.u = dp_q.u >> 1;
            dp_d.ia = half_mod(dp_q.ia, dp_q.p);
          end else if (!dp_q.v[0]) begin
            dp_d.v = dp_q.v >> 1;
            dp_d.ib = half_mod(dp_q.ib, dp_q.p);
          end else if (dp_q.u >= dp_q.v) begin
            dp_d.u = (dp_q.u - dp_q.v) >> 1;
            dp_d.ia = half_mod(sub_mod(dp_q.ia, dp_q.ib, dp_q.p), dp_q.p);
          end else begin
            dp_d.v = (dp_q.v - dp_q.u) >> 1;
            dp_d.ib = half_mod(sub_mod(dp_q.ib, dp_q.ia, dp_q.p), dp_q.p);
          end
        end
      end
      SLOPE: if (mul_last) begin
        dp_d.ma = acc_nx;
        dp_d.mb = acc_nx;
        dp_d.acc = '0;
        dp_d.cnt = '0;
        state_d = X3;
      end
      X3: if (mul_last) begin
        dp_d.rx = rx_new;
        dp_d.mb = sub_mod(dp_q.x1, rx_new, dp_q.p);
        dp_d.acc = '0;
        dp_d.cnt = '0;
        state_d = Y3;
      end
      Y3: if (mul_last) begin
        dp_d.ry = sub_mod(acc_nx, dp_q.y1, dp_q.p);
        state_d = DONE;
      end
      DONE: begin
        dp_d.x3 = dp_q.inf_pend ? '0 : dp_q.rx;
        dp_d.y3 = dp_q.inf_pend ? '0 : dp_q.ry;
        dp_d.result = !dp_q.inf_pend;
        dp_d.inf = dp_q.inf_pend;
        dp_d.busy = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dp_q <= '0;
    end else begin
      state_q <= state_d;
      dp_q <= dp_d;
    end
  end
  assign x3 = dp_q.x3;
  assign y3 = dp_q.y3;
  assign busy = dp_q.busy;
  assign result = dp_q.result;
  assign infinity = dp_q.inf;
endmodule

// File: tb/tb_point_subtraction.sv
// tb_point_subtraction: directed P - Q vectors on y^2 = x^3 + 2x + 2 over GF(17)
module tb_point_subtraction;
  localparam int N = 10;
`ifdef POINT_SUBTRACTION_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [N-1:0] p = 17, a = 2, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [N-1:0] x3, y3;
  logic busy, result, infinity;
  int checks = 0, errors = 0;
  point_subtraction #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .a(a),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .x3(x3), .y3(y3), .busy(busy), .result(result), .infinity(infinity)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input int res, input int inf, input int ex, input int ey);
    check({tag, "/result"}, result, res);
    check({tag, "/infinity"}, infinity, inf);
    check({tag, "/x3"}, x3, ex);
    check({tag, "/y3"}, y3, ey);
    check({tag, "/busy"}, busy, 0);
  endtask
  task automatic run_op(input string tag, input int px1, input int py1, input int px2, input int py2, input int mode);
    bit done;
    @(negedge clk);
    x1 = N'(px1);
    y1 = N'(py1);
    x2 = N'(px2);
    y2 = N'(py2);
    start = 1'b1;
    if (mode == 3) reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "/accept_busy"}, busy, 1);
    check({tag, "/accept_result"}, result, 0);
    check({tag, "/accept_inf"}, infinity, 0);
    done = 1'b0;
    for (int i = 0; i < 96 && !done; i++) begin
      if (mode == 1 && i == 10) begin
        x1 = 3;
        y1 = 1;
      end
      if (mode == 2 && i == 10) begin
        start = 1'b1;
        x1 = 10;
        y1 = 6;
      end
      if (mode == 2 && i == 13) start = 1'b0;
      @(posedge clk);
      #1;
      done = result | infinity;
    end
    start = 1'b0;
    check({tag, "/done_in_96"}, int'(done), 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("sub_g", 6, 3, 5, 1, 0);
    expect_out("sub_g", 1, 0, 5, 1);
    run_op("self", 5, 1, 5, 1, 0);
    expect_out("self", 0, 1, 0, 0);
    run_op("neg_q", 5, 1, 5, 16, 0);
    expect_out("neg_q", DBL, 1 - DBL, DBL * 6, DBL * 3);
    run_op("dbl_10g", 7, 11, 7, 6, 0);
    expect_out("dbl_10g", DBL, 1 - DBL, DBL * 5, DBL * 1);
    run_op("y_zero", 4, 0, 4, 0, 0);
    expect_out("y_zero", 0, 1, 0, 0);
    run_op("sub_3g", 10, 6, 5, 1, 0);
    expect_out("sub_3g", 1, 0, 6, 3);
    run_op("latched", 6, 3, 5, 1, 1);
    expect_out("latched", 1, 0, 5, 1);
    run_op("busy_start", 3, 1, 6, 3, 2);
    expect_out("busy_start", 1, 0, 6, 3);
    repeat (5) @(posedge clk);
    #1;
    expect_out("hold", 1, 0, 6, 3);
    @(negedge clk);
    x1 = 6;
    y1 = 3;
    x2 = 5;
    y2 = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    expect_out("mid_reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    run_op("after_rst", 6, 3, 5, 1, 3);
    expect_out("after_rst", 1, 0, 5, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
